// File: rtl/sum_acc_pkg.sv
// Shared state encoding and default widths for the sum_accumulator slice.
// The optional SUM_ACCUMULATOR_SATURATE_EN macro is consumed by acc_adder.
package sum_acc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEF_DATA_W  = 4;
  localparam int DEF_ACC_W   = 8;
  localparam int DEF_MAX_OPS = 4;

endpackage

// File: rtl/acc_adder.sv
// ACC_W-bit add with carry detection; wraps by default, clamps to all-ones
// when SUM_ACCUMULATOR_SATURATE_EN is defined.
module acc_adder #(
  parameter int ACC_W = sum_acc_pkg::DEF_ACC_W
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [ACC_W-1:0] operand,
  input  logic             ovf_in,
  output logic [ACC_W-1:0] result,
  output logic             carry
);

  logic [ACC_W:0] wide_sum;

  always_comb begin
    wide_sum = {1'b0, acc} + {1'b0, operand};
    carry    = wide_sum[ACC_W];
`ifdef SUM_ACCUMULATOR_SATURATE_EN
    // Once the run has overflowed the total stays pinned at all-ones.
    if (carry || ovf_in) begin
      result = '1;
    end else begin
      result = wide_sum[ACC_W-1:0];
    end
`else
    result = wide_sum[ACC_W-1:0];
`endif
  end

`ifndef SUM_ACCUMULATOR_SATURATE_EN
  logic unused_ovf;
  assign unused_ovf = ovf_in;
`endif

endmodule

// File: rtl/sum_accumulator.sv
// Accumulates {cout, sum} adder results over MAX_OPS beats and hands the total
// downstream. Build with SUM_ACCUMULATOR_SATURATE_EN to clamp instead of wrap.
module sum_accumulator
  import sum_acc_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ACC_W   = DEF_ACC_W,
  parameter int MAX_OPS = DEF_MAX_OPS
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_sum,
  input  logic              in_cout,
  input  logic              clear,
  output logic [ACC_W-1:0]  acc_out,
  output logic              acc_valid,
  input  logic              out_ready,
  output logic              overflow,
  output logic [3:0]        op_count
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_OPS);

  state_t           state, state_nx;
  logic [ACC_W-1:0] acc, acc_nx;
  logic [3:0]       cnt, cnt_nx;
  logic             ovf, ovf_nx;

  logic [ACC_W-1:0] operand;
  logic [ACC_W-1:0] add_result;
  logic             add_carry;
  logic             accept;

  assign operand = ACC_W'({in_cout, in_sum});
  assign accept  = in_valid && (state != DONE);

  acc_adder #(
    .ACC_W(ACC_W)
  ) u_adder (
    .acc    (acc),
    .operand(operand),
    .ovf_in (ovf),
    .result (add_result),
    .carry  (add_carry)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nx;
      acc   <= acc_nx;
      cnt   <= cnt_nx;
      ovf   <= ovf_nx;
    end
  end

  // clear beats both a beat and a DONE handoff presented in the same cycle.
  always_comb begin
    state_nx = state;
    acc_nx   = acc;
    cnt_nx   = cnt;
    ovf_nx   = ovf;
    if (clear) begin
      state_nx = IDLE;
      acc_nx   = '0;
      cnt_nx   = '0;
      ovf_nx   = 1'b0;
    end else begin
      unique case (state)
        IDLE, ACCUM: begin
          if (accept) begin
            acc_nx   = add_result;
            ovf_nx   = ovf | add_carry;
            cnt_nx   = cnt + 4'd1;
            state_nx = ((cnt + 4'd1) == MAX_CNT) ? DONE : ACCUM;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_nx = IDLE;
            acc_nx   = '0;
            cnt_nx   = '0;
            ovf_nx   = 1'b0;
          end
        end
        default: begin
          state_nx = IDLE;
          acc_nx   = '0;
          cnt_nx   = '0;
          ovf_nx   = 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = (state != DONE);
  assign acc_valid = (state == DONE);
  assign acc_out   = acc;
  assign overflow  = ovf;
  assign op_count  = cnt;

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed bench for sum_accumulator: main 8-bit/4-beat instance plus
// ACC_W=6 and MAX_OPS=1 instances.
module tb_sum_accumulator;

  logic       clock = 1'b0;
  logic       resetn;
  logic [3:0] in_sum;
  logic       in_cout;

  logic       a_valid, a_clear, a_ordy;
  logic       a_ready, a_accv, a_ovf;
  logic [7:0] a_acc;
  logic [3:0] a_cnt;

  logic       b_valid, b_clear, b_ordy;
  logic       b_ready, b_accv, b_ovf;
  logic [5:0] b_acc;
  logic [3:0] b_cnt;

  logic       c_valid, c_clear, c_ordy;
  logic       c_ready, c_accv, c_ovf;
  logic [7:0] c_acc;
  logic [3:0] c_cnt;

  int checkCount = 0;
  int passCount  = 0;
  int bExp;

  always #5 clock = ~clock;

  sum_accumulator #(.DATA_W(4), .ACC_W(8), .MAX_OPS(4)) dut_a (
    .clock(clock), .resetn(resetn), .in_valid(a_valid), .in_ready(a_ready),
    .in_sum(in_sum), .in_cout(in_cout), .clear(a_clear), .acc_out(a_acc),
    .acc_valid(a_accv), .out_ready(a_ordy), .overflow(a_ovf), .op_count(a_cnt)
  );

  sum_accumulator #(.DATA_W(4), .ACC_W(6), .MAX_OPS(4)) dut_b (
    .clock(clock), .resetn(resetn), .in_valid(b_valid), .in_ready(b_ready),
    .in_sum(in_sum), .in_cout(in_cout), .clear(b_clear), .acc_out(b_acc),
    .acc_valid(b_accv), .out_ready(b_ordy), .overflow(b_ovf), .op_count(b_cnt)
  );

  sum_accumulator #(.DATA_W(4), .ACC_W(8), .MAX_OPS(1)) dut_c (
    .clock(clock), .resetn(resetn), .in_valid(c_valid), .in_ready(c_ready),
    .in_sum(in_sum), .in_cout(in_cout), .clear(c_clear), .acc_out(c_acc),
    .acc_valid(c_accv), .out_ready(c_ordy), .overflow(c_ovf), .op_count(c_cnt)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed == expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
               tag, observed, observed, expected, expected);
    end
  endtask

  // Drives one cycle of inputs to the main instance and advances past the edge.
  task automatic applyStimulus(input logic v, input logic [3:0] s, input logic c,
                               input logic clr, input logic ordy);
    a_valid = v;
    in_sum  = s;
    in_cout = c;
    a_clear = clr;
    a_ordy  = ordy;
    tick();
  endtask

  initial begin
    resetn  = 1'b0;
    in_sum  = 4'h0;
    in_cout = 1'b0;
    {a_valid, a_clear, a_ordy} = 3'b000;
    {b_valid, b_clear, b_ordy} = 3'b000;
    {c_valid, c_clear, c_ordy} = 3'b000;
    repeat (2) tick();

    checkOutput("rst_acc", a_acc, 0);
    checkOutput("rst_ready", a_ready, 1);
    checkOutput("rst_valid", a_accv, 0);
    checkOutput("rst_ovf", a_ovf, 0);
    checkOutput("rst_cnt", a_cnt, 0);
    resetn = 1'b1;
    tick();

    // Reset mid-ACCUM after two beats
    applyStimulus(1, 4'hF, 1, 0, 0);
    applyStimulus(1, 4'hF, 1, 0, 0);
    checkOutput("pre_rst_acc", a_acc, 8'h3E);
    a_valid = 1'b0;
    resetn  = 1'b0;
    #1;
    checkOutput("midrst_acc", a_acc, 0);
    checkOutput("midrst_cnt", a_cnt, 0);
    checkOutput("midrst_valid", a_accv, 0);
    checkOutput("midrst_ready", a_ready, 1);
    checkOutput("midrst_ovf", a_ovf, 0);
    tick();
    resetn = 1'b1;
    tick();

    // Normal run with a two-cycle gap after beat 2
    applyStimulus(1, 4'hF, 1, 0, 0);
    checkOutput("run_cnt1", a_cnt, 1);
    checkOutput("run_acc1", a_acc, 8'h1F);
    applyStimulus(1, 4'hF, 1, 0, 0);
    checkOutput("run_cnt2", a_cnt, 2);
    applyStimulus(0, 4'hF, 1, 0, 0);
    checkOutput("run_gap1", a_cnt, 2);
    applyStimulus(0, 4'hF, 1, 0, 0);
    checkOutput("run_gap2", a_cnt, 2);
    applyStimulus(1, 4'hF, 1, 0, 0);
    checkOutput("run_cnt3", a_cnt, 3);
    checkOutput("run_acc3", a_acc, 8'h5D);
    checkOutput("run_valid3", a_accv, 0);
    applyStimulus(1, 4'hF, 1, 0, 0);
    checkOutput("run_cnt4", a_cnt, 4);
    checkOutput("run_acc4", a_acc, 8'h7C);
    checkOutput("run_valid4", a_accv, 1);
    checkOutput("run_ready4", a_ready, 0);
    checkOutput("run_ovf4", a_ovf, 0);

    // Backpressure in DONE with a beat on offer
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 4'hF, 1, 0, 0);
      checkOutput("bp_acc", a_acc, 8'h7C);
      checkOutput("bp_cnt", a_cnt, 4);
      checkOutput("bp_valid", a_accv, 1);
    end
    applyStimulus(1, 4'hF, 1, 0, 1);
    checkOutput("hand_acc", a_acc, 0);
    checkOutput("hand_ready", a_ready, 1);
    checkOutput("hand_valid", a_accv, 0);
    checkOutput("hand_cnt", a_cnt, 0);

    // out_ready outside DONE has no effect on an accept
    applyStimulus(1, 4'h1, 0, 0, 1);
    checkOutput("ordy_idle_cnt", a_cnt, 1);
    checkOutput("ordy_idle_acc", a_acc, 1);
    applyStimulus(0, 4'h0, 0, 1, 0);
    checkOutput("clr_idle_acc", a_acc, 0);

    // Clear wins over a simultaneous beat
    applyStimulus(1, 4'hF, 1, 0, 0);
    applyStimulus(1, 4'hF, 1, 0, 0);
    checkOutput("clr_pre_acc", a_acc, 8'h3E);
    applyStimulus(1, 4'hF, 1, 1, 0);
    checkOutput("clr_acc", a_acc, 0);
    checkOutput("clr_cnt", a_cnt, 0);
    checkOutput("clr_ready", a_ready, 1);
    checkOutput("clr_valid", a_accv, 0);
    for (int i = 0; i < 4; i++) applyStimulus(1, 4'hF, 1, 0, 0);
    checkOutput("clr_run_acc", a_acc, 8'h7C);
    checkOutput("clr_run_valid", a_accv, 1);
    applyStimulus(0, 4'h0, 0, 0, 1);
    checkOutput("clr_run_hand", a_acc, 0);

    // Overflow on the 6-bit instance
    in_sum  = 4'hF;
    in_cout = 1'b1;
    b_valid = 1'b1;
    tick();
    checkOutput("ovf_acc1", b_acc, 31);
    tick();
    checkOutput("ovf_acc2", b_acc, 62);
    checkOutput("ovf_flag2", b_ovf, 0);
    tick();
`ifdef SUM_ACCUMULATOR_SATURATE_EN
    bExp = 63;
`else
    bExp = 29;
`endif
    checkOutput("ovf_acc3", b_acc, bExp);
    checkOutput("ovf_flag3", b_ovf, 1);
    tick();
    b_valid = 1'b0;
`ifdef SUM_ACCUMULATOR_SATURATE_EN
    bExp = 63;
`else
    bExp = 60;
`endif
    checkOutput("ovf_acc4", b_acc, bExp);
    checkOutput("ovf_flag4", b_ovf, 1);
    checkOutput("ovf_valid4", b_accv, 1);
    b_ordy = 1'b1;
    tick();
    b_ordy = 1'b0;
    checkOutput("ovf_hand_flag", b_ovf, 0);
    checkOutput("ovf_hand_acc", b_acc, 0);

    // MAX_OPS=1 instance
    in_sum  = 4'd5;
    in_cout = 1'b0;
    c_valid = 1'b1;
    tick();
    c_valid = 1'b0;
    checkOutput("one_acc", c_acc, 5);
    checkOutput("one_valid", c_accv, 1);
    checkOutput("one_cnt", c_cnt, 1);
    checkOutput("one_ready", c_ready, 0);
    c_ordy  = 1'b1;
    c_clear = 1'b1;
    tick();
    c_ordy  = 1'b0;
    c_clear = 1'b0;
    checkOutput("one_clr_acc", c_acc, 0);
    checkOutput("one_clr_valid", c_accv, 0);
    checkOutput("one_clr_ready", c_ready, 1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
